calendar_counter_gen: RTL and testbench

Parametrised successor to the fixed second-to-year timekeeper chain. Single-module calendar counter: sec/min/hour/day/month/year plus day-of-week, with a configurable year window and an optional 12-hour display. It also adds atomic validated loading, day-of-month clamping and a year-wrap flag. Sits between the 1 Hz tick domain and the BCD/display path; drop-in for the existing counter at top level.

---
 rtl/calendar_pkg.sv | 35 +++
 rtl/month_length.sv | 23 ++
 rtl/calendar_counter_gen.sv | 218 +++++++++++++++++++++
 tb/tb_calendar_counter_gen.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calendar_pkg.sv
// Shared select codes, field limits and calendar helpers for the calendar counter.
package calendar_pkg;

   typedef enum logic [2:0] {
      SEL_SEC   = 3'd0,
      SEL_MIN   = 3'd1,
      SEL_HOUR  = 3'd2,
      SEL_DAY   = 3'd3,
      SEL_MONTH = 3'd4,
      SEL_YEAR  = 3'd5,
      SEL_DOW   = 3'd6,
      SEL_NONE  = 3'd7
   } sel_e;

   localparam logic [5:0] SEC_MAX   = 6'd59;
   localparam logic [5:0] MIN_MAX   = 6'd59;
   localparam logic [4:0] HOUR_MAX  = 5'd23;
   localparam logic [3:0] MONTH_MAX = 4'd12;
   localparam logic [2:0] DOW_MAX   = 3'd6;

   function automatic logic is_leap(input int unsigned year);
      return (((year % 4) == 0) && ((year % 100) != 0)) || ((year % 400) == 0);
   endfunction

   function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic leap);
      logic [4:0] days;
      case (month)
         4'd2:                     days = leap ? 5'd29 : 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11:  days = 5'd30;
         default:                  days = 5'd31;
      endcase
      return days;
   endfunction

endpackage

// File: rtl/month_length.sv
// Month lengths and leap flag for the running date and for a pending load date.
module month_length
   import calendar_pkg::*;
#(
   parameter int unsigned YEAR_W = 12
) (
   input  logic [3:0]        cur_month_i,
   input  logic [YEAR_W-1:0] cur_year_i,
   input  logic [3:0]        ld_month_i,
   input  logic [YEAR_W-1:0] ld_year_i,
   output logic              cur_leap_o,
   output logic [4:0]        cur_days_o,
   output logic [4:0]        ld_days_o
);

   logic ld_leap;

   assign cur_leap_o = is_leap(32'(cur_year_i));
   assign ld_leap    = is_leap(32'(ld_year_i));
   assign cur_days_o = days_in_month(cur_month_i, cur_leap_o);
   assign ld_days_o  = days_in_month(ld_month_i, ld_leap);

endmodule

// File: rtl/calendar_counter_gen.sv
// Calendar counter: sec..year plus day-of-week, with validated atomic load, set-mode
// field adjust with day clamping, and day/year rollover pulses.
module calendar_counter_gen
   import calendar_pkg::*;
#(
   parameter int unsigned YEAR_W   = 12,
   parameter int unsigned YEAR_MIN = 2001,
   parameter int unsigned YEAR_MAX = 3000,
   parameter bit          HOUR_12  = 1'b0,
   parameter logic [2:0]  DOW_INIT = 3'd1
) (
   input  logic              clk_1Hz,
   input  logic              rst,
   input  logic              en_1,
   input  logic              up,
   input  logic              down,
   input  logic [2:0]        select_item,
   input  logic              load_valid,
   input  logic [5:0]        load_sec,
   input  logic [5:0]        load_min,
   input  logic [4:0]        load_hour,
   input  logic [4:0]        load_day,
   input  logic [3:0]        load_month,
   input  logic [YEAR_W-1:0] load_year,
   input  logic [2:0]        load_dow,
   output logic              load_ready,
   output logic              load_err,
   output logic [5:0]        sec_bin,
   output logic [5:0]        min_bin,
   output logic [4:0]        hour_bin,
   output logic [4:0]        hour_disp,
   output logic              pm,
   output logic [4:0]        day_bin,
   output logic [3:0]        month_bin,
   output logic [YEAR_W-1:0] year_bin,
   output logic [2:0]        dow,
   output logic              leap_year,
   output logic              day_tick,
   output logic              year_wrap
);

   localparam logic [YEAR_W-1:0] YMIN = YEAR_W'(YEAR_MIN);
   localparam logic [YEAR_W-1:0] YMAX = YEAR_W'(YEAR_MAX);
   localparam logic [YEAR_W-1:0] YONE = YEAR_W'(1);

   logic [5:0]        sec_q, sec_d, min_q, min_d;
   logic [4:0]        hour_q, hour_d, day_q, day_d;
   logic [3:0]        month_q, month_d;
   logic [YEAR_W-1:0] year_q, year_d;
   logic [2:0]        dow_q, dow_d;
   logic              load_ready_q, load_ready_d, load_err_q, load_err_d;
   logic              day_tick_q, day_tick_d, year_wrap_q, year_wrap_d;

   logic [4:0] cur_days, ld_days, clamp_days;
   logic       cur_leap, load_ok;
   logic       min_roll, hour_roll, day_roll, month_roll;
   sel_e       sel;

   assign sel = sel_e'(select_item);

   month_length #(
      .YEAR_W (YEAR_W)
   ) u_month_length (
      .cur_month_i (month_q),
      .cur_year_i  (year_q),
      .ld_month_i  (load_month),
      .ld_year_i   (load_year),
      .cur_leap_o  (cur_leap),
      .cur_days_o  (cur_days),
      .ld_days_o   (ld_days)
   );

   assign load_ok = (load_sec <= SEC_MAX) && (load_min <= MIN_MAX) && (load_hour <= HOUR_MAX)
                 && (load_month != 4'd0) && (load_month <= MONTH_MAX)
                 && (load_year >= YMIN) && (load_year <= YMAX)
                 && (load_day != 5'd0) && (load_day <= ld_days) && (load_dow <= DOW_MAX);

   // Whole carry chain resolves combinationally from the current registers.
   assign min_roll   = (sec_q == SEC_MAX) && (min_q == MIN_MAX);
   assign hour_roll  = min_roll && (hour_q == HOUR_MAX);
   assign day_roll   = hour_roll && (day_q == cur_days);
   assign month_roll = day_roll && (month_q == MONTH_MAX);

   always_comb begin
      sec_d        = sec_q;
      min_d        = min_q;
      hour_d       = hour_q;
      day_d        = day_q;
      month_d      = month_q;
      year_d       = year_q;
      dow_d        = dow_q;
      load_ready_d = load_valid;
      load_err_d   = 1'b0;
      day_tick_d   = 1'b0;
      year_wrap_d  = 1'b0;
      clamp_days   = cur_days;
      if (load_valid) begin
         if (load_ok) begin
            sec_d   = load_sec;
            min_d   = load_min;
            hour_d  = load_hour;
            day_d   = load_day;
            month_d = load_month;
            year_d  = load_year;
            dow_d   = load_dow;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (en_1) begin
         sec_d = (sec_q == SEC_MAX) ? 6'd0 : sec_q + 6'd1;
         if (sec_q == SEC_MAX) begin
            min_d = (min_q == MIN_MAX) ? 6'd0 : min_q + 6'd1;
         end
         if (min_roll) begin
            hour_d = (hour_q == HOUR_MAX) ? 5'd0 : hour_q + 5'd1;
         end
         if (hour_roll) begin
            dow_d      = (dow_q == DOW_MAX) ? 3'd0 : dow_q + 3'd1;
            day_d      = (day_q == cur_days) ? 5'd1 : day_q + 5'd1;
            day_tick_d = 1'b1;
         end
         if (day_roll) begin
            month_d = (month_q == MONTH_MAX) ? 4'd1 : month_q + 4'd1;
         end
         if (month_roll) begin
            year_d      = (year_q == YMAX) ? YMIN : year_q + YONE;
            year_wrap_d = (year_q == YMAX);
         end
      end else if (up ^ down) begin
         unique case (sel)
            SEL_SEC: begin
               if (up) sec_d = (sec_q >= SEC_MAX) ? 6'd0 : sec_q + 6'd1;
               else    sec_d = (sec_q == 6'd0) ? SEC_MAX : sec_q - 6'd1;
            end
            SEL_MIN: begin
               if (up) min_d = (min_q >= MIN_MAX) ? 6'd0 : min_q + 6'd1;
               else    min_d = (min_q == 6'd0) ? MIN_MAX : min_q - 6'd1;
            end
            SEL_HOUR: begin
               if (up) hour_d = (hour_q >= HOUR_MAX) ? 5'd0 : hour_q + 5'd1;
               else    hour_d = (hour_q == 5'd0) ? HOUR_MAX : hour_q - 5'd1;
            end
            SEL_DAY: begin
               if (up) day_d = (day_q >= cur_days) ? 5'd1 : day_q + 5'd1;
               else    day_d = (day_q <= 5'd1) ? cur_days : day_q - 5'd1;
            end
            SEL_MONTH: begin
               if (up) month_d = (month_q >= MONTH_MAX) ? 4'd1 : month_q + 4'd1;
               else    month_d = (month_q <= 4'd1) ? MONTH_MAX : month_q - 4'd1;
            end
            SEL_YEAR: begin
               if (up) year_d = (year_q >= YMAX) ? YMIN : year_q + YONE;
               else    year_d = (year_q <= YMIN) ? YMAX : year_q - YONE;
            end
            SEL_DOW: begin
               if (up) dow_d = (dow_q >= DOW_MAX) ? 3'd0 : dow_q + 3'd1;
               else    dow_d = (dow_q == 3'd0) ? DOW_MAX : dow_q - 3'd1;
            end
            default: ;
         endcase
         // A month or year change can shorten the month under the current day.
         clamp_days = days_in_month(month_d, is_leap(32'(year_d)));
         if (day_d > clamp_days) day_d = clamp_days;
      end
   end

   always_ff @(posedge clk_1Hz) begin
      if (rst) begin
         sec_q        <= 6'd0;
         min_q        <= 6'd0;
         hour_q       <= 5'd0;
         day_q        <= 5'd1;
         month_q      <= 4'd1;
         year_q       <= YMIN;
         dow_q        <= DOW_INIT;
         load_ready_q <= 1'b0;
         load_err_q   <= 1'b0;
         day_tick_q   <= 1'b0;
         year_wrap_q  <= 1'b0;
      end else begin
         sec_q        <= sec_d;
         min_q        <= min_d;
         hour_q       <= hour_d;
         day_q        <= day_d;
         month_q      <= month_d;
         year_q       <= year_d;
         dow_q        <= dow_d;
         load_ready_q <= load_ready_d;
         load_err_q   <= load_err_d;
         day_tick_q   <= day_tick_d;
         year_wrap_q  <= year_wrap_d;
      end
   end

   always_comb begin
      hour_disp = hour_q;
      pm        = 1'b0;
      if (HOUR_12) begin
         if (hour_q == 5'd0)       hour_disp = 5'd12;
         else if (hour_q > 5'd12)  hour_disp = hour_q - 5'd12;
         pm = (hour_q >= 5'd12);
      end
   end

   assign sec_bin    = sec_q;
   assign min_bin    = min_q;
   assign hour_bin   = hour_q;
   assign day_bin    = day_q;
   assign month_bin  = month_q;
   assign year_bin   = year_q;
   assign dow        = dow_q;
   assign leap_year  = cur_leap;
   assign load_ready = load_ready_q;
   assign load_err   = load_err_q;
   assign day_tick   = day_tick_q;
   assign year_wrap  = year_wrap_q;

endmodule

// File: tb/tb_calendar_counter_gen.sv
// Directed and randomized checks of calendar_counter_gen against a date/time model.
module tb_calendar_counter_gen;

   localparam int YW   = 12;
   localparam int YMIN = 2001;
   localparam int YMAX = 3000;

   logic          clk_1Hz = 1'b0;
   logic          rst, en_1, up, down, load_valid;
   logic [2:0]    select_item, load_dow;
   logic [5:0]    load_sec, load_min;
   logic [4:0]    load_hour, load_day;
   logic [3:0]    load_month;
   logic [YW-1:0] load_year;

   logic          load_ready, load_err, pm, leap_year, day_tick, year_wrap;
   logic [5:0]    sec_bin, min_bin;
   logic [4:0]    hour_bin, hour_disp, day_bin;
   logic [3:0]    month_bin;
   logic [YW-1:0] year_bin;
   logic [2:0]    dow;

   logic          load_ready_b, load_err_b, pm_b, leap_year_b, day_tick_b, year_wrap_b;
   logic [5:0]    sec_bin_b, min_bin_b;
   logic [4:0]    hour_bin_b, hour_disp_b, day_bin_b;
   logic [3:0]    month_bin_b;
   logic [YW-1:0] year_bin_b;
   logic [2:0]    dow_b;

   int tests = 0;
   int fails = 0;
   int m_sec, m_min, m_hour, m_day, m_month, m_year, m_dow;
   int m_tick, m_wrap, m_rdy, m_err;

   always #5 clk_1Hz = ~clk_1Hz;

   calendar_counter_gen #(
      .YEAR_W (YW), .YEAR_MIN (YMIN), .YEAR_MAX (YMAX), .HOUR_12 (1'b1), .DOW_INIT (3'd1)
   ) dut (
      .clk_1Hz (clk_1Hz), .rst (rst), .en_1 (en_1), .up (up), .down (down),
      .select_item (select_item), .load_valid (load_valid), .load_sec (load_sec),
      .load_min (load_min), .load_hour (load_hour), .load_day (load_day),
      .load_month (load_month), .load_year (load_year), .load_dow (load_dow),
      .load_ready (load_ready), .load_err (load_err), .sec_bin (sec_bin), .min_bin (min_bin),
      .hour_bin (hour_bin), .hour_disp (hour_disp), .pm (pm), .day_bin (day_bin),
      .month_bin (month_bin), .year_bin (year_bin), .dow (dow), .leap_year (leap_year),
      .day_tick (day_tick), .year_wrap (year_wrap)
   );

   calendar_counter_gen #(
      .YEAR_W (YW), .YEAR_MIN (YMIN), .YEAR_MAX (YMAX), .HOUR_12 (1'b0), .DOW_INIT (3'd1)
   ) dut24 (
      .clk_1Hz (clk_1Hz), .rst (rst), .en_1 (en_1), .up (up), .down (down),
      .select_item (select_item), .load_valid (load_valid), .load_sec (load_sec),
      .load_min (load_min), .load_hour (load_hour), .load_day (load_day),
      .load_month (load_month), .load_year (load_year), .load_dow (load_dow),
      .load_ready (load_ready_b), .load_err (load_err_b), .sec_bin (sec_bin_b),
      .min_bin (min_bin_b), .hour_bin (hour_bin_b), .hour_disp (hour_disp_b), .pm (pm_b),
      .day_bin (day_bin_b), .month_bin (month_bin_b), .year_bin (year_bin_b), .dow (dow_b),
      .leap_year (leap_year_b), .day_tick (day_tick_b), .year_wrap (year_wrap_b)
   );

   function automatic int m_leap(input int y);
      return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
   endfunction

   function automatic int m_dim(input int m, input int y);
      if (m == 2) return m_leap(y) ? 29 : 28;
      if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
      return 31;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Next expected state from the current inputs, computed from calendar rules.
   task automatic model_step();
      int dlt;
      int span;
      int tod;
      int dim;
      m_tick = 0;
      m_wrap = 0;
      m_err  = 0;
      m_rdy  = (load_valid && !rst) ? 1 : 0;
      if (rst) begin
         m_sec = 0; m_min = 0; m_hour = 0; m_day = 1; m_month = 1; m_year = YMIN; m_dow = 1;
      end else if (load_valid) begin
         if (int'(load_sec) < 60 && int'(load_min) < 60 && int'(load_hour) < 24
             && int'(load_month) >= 1 && int'(load_month) <= 12
             && int'(load_year) >= YMIN && int'(load_year) <= YMAX && int'(load_day) >= 1
             && int'(load_day) <= m_dim(int'(load_month), int'(load_year))
             && int'(load_dow) < 7) begin
            m_sec = int'(load_sec); m_min = int'(load_min); m_hour = int'(load_hour);
            m_day = int'(load_day); m_month = int'(load_month); m_year = int'(load_year);
            m_dow = int'(load_dow);
         end else begin
            m_err = 1;
         end
      end else if (en_1) begin
         tod = m_hour * 3600 + m_min * 60 + m_sec + 1;
         if (tod == 86400) begin
            tod    = 0;
            m_tick = 1;
            m_dow  = (m_dow + 1) % 7;
            m_day++;
            if (m_day > m_dim(m_month, m_year)) begin
               m_day = 1;
               m_month++;
               if (m_month > 12) begin
                  m_month = 1;
                  m_year++;
                  if (m_year > YMAX) begin
                     m_year = YMIN;
                     m_wrap = 1;
                  end
               end
            end
         end
         m_hour = tod / 3600;
         m_min  = (tod / 60) % 60;
         m_sec  = tod % 60;
      end else if (up != down) begin
         dlt  = up ? 1 : -1;
         span = YMAX - YMIN + 1;
         dim  = m_dim(m_month, m_year);
         case (select_item)
            3'd0: m_sec   = (m_sec + dlt + 60) % 60;
            3'd1: m_min   = (m_min + dlt + 60) % 60;
            3'd2: m_hour  = (m_hour + dlt + 24) % 24;
            3'd3: m_day   = ((m_day - 1 + dlt + dim) % dim) + 1;
            3'd4: m_month = ((m_month - 1 + dlt + 12) % 12) + 1;
            3'd5: m_year  = YMIN + ((m_year - YMIN + dlt + span) % span);
            3'd6: m_dow   = (m_dow + dlt + 7) % 7;
            default: ;
         endcase
         if (m_day > m_dim(m_month, m_year)) m_day = m_dim(m_month, m_year);
      end
   endtask

   task automatic check_all(input string tag);
      int hd;
      hd = (m_hour == 0) ? 12 : ((m_hour > 12) ? m_hour - 12 : m_hour);
      chk({tag, " sec"},        32'(sec_bin),      m_sec);
      chk({tag, " min"},        32'(min_bin),      m_min);
      chk({tag, " hour"},       32'(hour_bin),     m_hour);
      chk({tag, " day"},        32'(day_bin),      m_day);
      chk({tag, " month"},      32'(month_bin),    m_month);
      chk({tag, " year"},       32'(year_bin),     m_year);
      chk({tag, " dow"},        32'(dow),          m_dow);
      chk({tag, " leap"},       32'(leap_year),    m_leap(m_year));
      chk({tag, " day_tick"},   32'(day_tick),     m_tick);
      chk({tag, " year_wrap"},  32'(year_wrap),    m_wrap);
      chk({tag, " load_ready"}, 32'(load_ready),   m_rdy);
      chk({tag, " load_err"},   32'(load_err),     m_err);
      chk({tag, " hour_disp"},  32'(hour_disp),    hd);
      chk({tag, " pm"},         32'(pm),           (m_hour >= 12) ? 1 : 0);
      chk({tag, " disp24"},     32'(hour_disp_b),  m_hour);
      chk({tag, " pm24"},       32'(pm_b),         0);
      chk({tag, " day24"},      32'(day_bin_b),    m_day);
   endtask

   task automatic step(input string tag);
      model_step();
      @(posedge clk_1Hz);
      #1;
      check_all(tag);
   endtask

   task automatic do_load(input string tag, input int h, input int mi, input int s,
                          input int d, input int mo, input int y, input int w);
      load_hour  = 5'(h);
      load_min   = 6'(mi);
      load_sec   = 6'(s);
      load_day   = 5'(d);
      load_month = 4'(mo);
      load_year  = YW'(y);
      load_dow   = 3'(w);
      load_valid = 1'b1;
      step(tag);
      load_valid = 1'b0;
   endtask

   initial begin
      m_sec = 0; m_min = 0; m_hour = 0; m_day = 1; m_month = 1; m_year = YMIN; m_dow = 1;
      m_tick = 0; m_wrap = 0; m_rdy = 0; m_err = 0;
      rst = 1'b1; en_1 = 1'b0; up = 1'b0; down = 1'b0; select_item = 3'd7;
      load_valid = 1'b0; load_sec = '0; load_min = '0; load_hour = '0; load_day = 5'd1;
      load_month = 4'd1; load_year = YW'(YMIN); load_dow = '0;
      step("reset");
      rst = 1'b0;
      step("idle");

      en_1 = 1'b1;
      do_load("ld2004", 23, 59, 59, 28, 2, 2004, 6);
      step("leapday");
      do_load("ld2100", 23, 59, 59, 28, 2, 2100, 0);
      step("noleap2100");
      do_load("ld3000", 23, 59, 59, 31, 12, 3000, 2);
      step("yearwrap");
      step("afterwrap");

      en_1 = 1'b0;
      do_load("ld2023", 0, 0, 0, 1, 3, 2023, 3);
      select_item = 3'd3; down = 1'b1;
      step("daywrap");
      select_item = 3'd4;
      step("monclamp");
      down = 1'b0;
      do_load("ld2024", 0, 0, 0, 31, 1, 2024, 3);
      select_item = 3'd4; up = 1'b1;
      step("monclampleap");
      up = 1'b0;

      do_load("baddaymon", 10, 0, 0, 30, 2, 2024, 1);
      do_load("badhour", 24, 0, 0, 1, 1, 2024, 1);
      do_load("badyear", 1, 0, 0, 1, 1, 3001, 1);
      step("afterbad");

      do_load("h0", 0, 5, 5, 10, 5, 2010, 1);
      do_load("h12", 12, 5, 5, 10, 5, 2010, 1);
      do_load("h13", 13, 5, 5, 10, 5, 2010, 1);
      select_item = 3'd2; up = 1'b1; down = 1'b1;
      step("updown");
      down = 1'b0;
      step("hourup");
      select_item = 3'd7;
      step("selnone");
      up = 1'b0; en_1 = 1'b1; rst = 1'b1; load_valid = 1'b1;
      step("rstload");
      rst = 1'b0; load_valid = 1'b0;

      for (int i = 0; i < 600; i++) begin
         rst         = ($urandom_range(0, 59) == 0);
         load_valid  = ($urandom_range(0, 5) == 0);
         load_sec    = 6'(($urandom_range(0, 9) == 0) ? 60 : $urandom_range(56, 59));
         load_min    = 6'($urandom_range(58, 59));
         load_hour   = 5'(($urandom_range(0, 9) == 0) ? 24 : $urandom_range(22, 23));
         load_day    = 5'($urandom_range(27, 31));
         load_month  = 4'(($urandom_range(0, 15) == 0) ? 13 : $urandom_range(1, 12));
         case ($urandom_range(0, 7))
            0:       load_year = YW'(2004);
            1:       load_year = YW'(2100);
            2:       load_year = YW'(2400);
            3:       load_year = YW'(YMAX);
            4:       load_year = YW'(YMIN);
            5:       load_year = YW'(($urandom_range(0, 3) == 0) ? YMAX + 1 : YMIN - 1);
            default: load_year = YW'(YMIN + $urandom_range(0, YMAX - YMIN));
         endcase
         load_dow    = 3'(($urandom_range(0, 15) == 0) ? 7 : $urandom_range(0, 6));
         en_1        = ($urandom_range(0, 2) != 0);
         select_item = 3'($urandom_range(0, 7));
         up          = 1'($urandom_range(0, 1));
         down        = 1'($urandom_range(0, 1));
         step("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
